// File: rtl/wb_single_master.sv
// Single-outstanding Wishbone classic master.
// Takes one command over a valid/ready handshake and runs it as one Wishbone
// cycle. The transfer ends on ack_i, err_i, or after TIMEOUT cycles with no
// answer. The result is held on a valid/ready response port until consumed.
module wb_single_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    // response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_to,
    // Wishbone master
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value at which a silent slave is abandoned; reached on the
    // TIMEOUT-th BUS edge, so stb_o stays high for exactly TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    // Only an idle master can take a new command; this is the one
    // combinational output.
    assign cmd_ready = (state == IDLE);

    // Transfer sequencer: accept, run the bus cycle, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= 32'd0;
            dat_o     <= 32'd0;
            sel_o     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b0;
            rsp_to    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        we_o     <= cmd_we;
                        adr_o    <= cmd_adr;
                        dat_o    <= cmd_dat;
                        sel_o    <= cmd_sel;
                        cyc_o    <= 1'b1;
                        stb_o    <= 1'b1;
                        wait_cnt <= 8'd0;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    // A slave answer is checked first so it beats a timeout
                    // landing on the same edge; err_i beats a coincident ack_i.
                    if (ack_i || err_i) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (err_i) begin
                            rsp_err <= 1'b1;
                            rsp_dat <= 32'd0;
                        end else begin
                            rsp_dat <= we_o ? 32'd0 : dat_i;
                        end
                        state <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_to    <= 1'b1;
                        rsp_dat   <= 32'd0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    // rsp_dat is left as is; it is only meaningful with rsp_valid.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_to    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_single_master.sv
// Bench for wb_single_master: scenario tasks with a cycle-count reference model.
module tb_wb_single_master;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_to;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    int tests;
    int fails;

    wb_single_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_to(rsp_to),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // Runs one command from an IDLE negedge. mode: 0 ack, 1 err, 2 ack+err,
    // 3 silent slave. w = slave wait cycles after stb_o is first seen.
    // Cycle numbering: T0 offers the command, stb_o is seen from T1, an answer
    // w cycles late is driven during T(2+w), the response shows the cycle after.
    task automatic run_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int w, input int mode,
                            input logic [31:0] rdat, input int hold, input string name);
        int          ack_cycle;
        int          resp_cycle;
        int          got;
        int          stb_cnt;
        bit          held_ok;
        bit          stable_ok;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_dat;

        // reference model
        ack_cycle = 2 + w;
        if (mode != 3 && ack_cycle <= TO) begin
            resp_cycle = ack_cycle + 1;
            exp_to     = 1'b0;
            exp_err    = (mode != 0);
            exp_dat    = exp_err ? 32'd0 : (we ? 32'd0 : rdat);
        end else begin
            resp_cycle = TO + 1;
            exp_to     = 1'b1;
            exp_err    = 1'b0;
            exp_dat    = 32'd0;
        end

        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        rsp_ready = 1'b0;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s cmd_ready_idle: got %b expected 1", name, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = ~adr;
        cmd_dat   = ~dat;
        cmd_sel   = ~sel;

        got       = 0;
        stb_cnt   = 0;
        held_ok   = 1'b1;
        for (int k = 1; k <= TO + 5; k++) begin
            ack_i = 1'b0;
            err_i = 1'b0;
            dat_i = $urandom;
            if (rsp_valid === 1'b1) begin
                got = k;
                break;
            end
            if (cyc_o === 1'b1 && stb_o === 1'b1) stb_cnt++;
            if (cyc_o !== 1'b1 || stb_o !== 1'b1 || we_o !== we || adr_o !== adr ||
                dat_o !== dat || sel_o !== sel || cmd_ready !== 1'b0)
                held_ok = 1'b0;
            if (k == ack_cycle && mode != 3) begin
                ack_i = (mode != 1);
                err_i = (mode != 0);
                dat_i = rdat;
            end
            @(negedge clk);
        end

        tests++;
        if (got != resp_cycle) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, got, resp_cycle);
        end
        tests++;
        if (!held_ok) begin
            fails++;
            $display("FAIL %s bus_hold: bus outputs not held during transfer (we %b adr %h dat %h sel %h)",
                     name, we_o, adr_o, dat_o, sel_o);
        end
        tests++;
        if (stb_cnt != resp_cycle - 1) begin
            fails++;
            $display("FAIL %s stb_cycles: got %0d expected %0d", name, stb_cnt, resp_cycle - 1);
        end
        tests++;
        if (rsp_dat !== exp_dat || rsp_err !== exp_err || rsp_to !== exp_to ||
            cyc_o !== 1'b0 || stb_o !== 1'b0) begin
            fails++;
            $display("FAIL %s response: got dat=%h err=%b to=%b cyc=%b stb=%b expected dat=%h err=%b to=%b cyc=0 stb=0",
                     name, rsp_dat, rsp_err, rsp_to, cyc_o, stb_o, exp_dat, exp_err, exp_to);
        end

        // consumer stalls; stray slave strobes must be ignored
        stable_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            ack_i = 1'($urandom_range(0, 1));
            err_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== exp_dat || rsp_err !== exp_err ||
                rsp_to !== exp_to || cmd_ready !== 1'b0 || cyc_o !== 1'b0)
                stable_ok = 1'b0;
        end
        tests++;
        if (!stable_ok) begin
            fails++;
            $display("FAIL %s resp_stable: got valid=%b dat=%h err=%b to=%b ready=%b expected valid=1 dat=%h err=%b to=%b ready=0",
                     name, rsp_valid, rsp_dat, rsp_err, rsp_to, cmd_ready, exp_dat, exp_err, exp_to);
        end

        ack_i     = 1'b0;
        err_i     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_to !== 1'b0 ||
            cmd_ready !== 1'b1 || cyc_o !== 1'b0) begin
            fails++;
            $display("FAIL %s release: got valid=%b err=%b to=%b ready=%b cyc=%b expected 0 0 0 1 0",
                     name, rsp_valid, rsp_err, rsp_to, cmd_ready, cyc_o);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'd0;
        cmd_dat   = 32'd0;
        cmd_sel   = 4'd0;
        rsp_ready = 1'b0;
        dat_i     = 32'd0;
        ack_i     = 1'b0;
        err_i     = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0 || we_o !== 1'b0 || adr_o !== 32'd0 ||
            dat_o !== 32'd0 || sel_o !== 4'd0) begin
            fails++;
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h expected all 0",
                     cyc_o, stb_o, we_o, adr_o, dat_o, sel_o);
        end
        tests++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_to !== 1'b0 || rsp_dat !== 32'd0) begin
            fails++;
            $display("FAIL reset_rsp: got valid=%b err=%b to=%b dat=%h expected all 0",
                     rsp_valid, rsp_err, rsp_to, rsp_dat);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_read_basic();
        run_xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 0, 32'hC000_0000, 0, "read_basic");
    endtask

    task automatic test_write_wait();
        run_xfer(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 3, 0, 32'hDEAD_BEEF, 1, "write_wait");
    endtask

    task automatic test_timeout();
        run_xfer(1'b0, 32'h0000_0100, 32'h0, 4'h3, 0, 3, 32'h0, 2, "timeout");
    endtask

    task automatic test_err_ack_hold();
        run_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, 2, 32'h1234_5678, 5, "err_ack_hold");
    endtask

    task automatic test_tie_timeout();
        // answer on the final allowed edge beats the timeout
        run_xfer(1'b0, 32'h0000_0300, 32'h0, 4'hF, TO - 2, 0, 32'h5555_AAAA, 0, "ack_on_timeout_edge");
        // one cycle later is too late
        run_xfer(1'b0, 32'h0000_0304, 32'h0, 4'hF, TO - 1, 0, 32'h5555_AAAA, 0, "ack_after_timeout");
    endtask

    task automatic test_idle_ack_ignored();
        cmd_valid = 1'b0;
        ack_i     = 1'b1;
        err_i     = 1'b1;
        dat_i     = 32'hFFFF_FFFF;
        @(negedge clk);
        ack_i = 1'b0;
        err_i = 1'b0;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_ack: got valid=%b cyc=%b ready=%b expected 0 0 1",
                     rsp_valid, cyc_o, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h0000_0500;
        cmd_dat   = 32'h0BAD_F00D;
        cmd_sel   = 4'hC;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (stb_o !== 1'b1 || cyc_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pre: got cyc=%b stb=%b expected 1 1", cyc_o, stb_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: got cyc=%b stb=%b expected 0 0", cyc_o, stb_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            ack_i = 1'b1;
            @(negedge clk);
        end
        ack_i = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_discard: got valid=%b ready=%b cyc=%b expected 0 1 0",
                     rsp_valid, cmd_ready, cyc_o);
        end
        run_xfer(1'b0, 32'h0000_0504, 32'h0, 4'hF, 0, 0, 32'h7777_0001, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b1, 32'h0000_0600, 32'h1111_2222, 4'h1, 0, 0, 32'h0, 0, "b2b_0");
        run_xfer(1'b0, 32'h0000_0604, 32'h0, 4'hF, 0, 0, 32'h3333_4444, 0, "b2b_1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, TO), $urandom_range(0, 3), $urandom,
                     $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_read_basic();
        test_write_wait();
        test_timeout();
        test_err_ack_hold();
        test_tie_timeout();
        test_idle_ack_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
